// File: rtl/obuf_read_controller_if.sv
// obuf_read_controller_if: control, RAM read and output-stream signals of the output-buffer drain controller.
interface obuf_read_controller_if #(
  parameter int RAM_O_SIZE = 256,
  parameter int ARRAY_M = 8,
  parameter int DATA_WIDTH = 16
);
  localparam int ADDR_WIDTH = $clog2(RAM_O_SIZE);
  localparam int ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M;
  logic start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0] num_rows;
  logic [$clog2(ARRAY_M):0] num_cols;
  logic [ADDR_SET_WIDTH-1:0] addr_set;
  logic [ARRAY_M-1:0] enable_set;
  logic [ARRAY_M*DATA_WIDTH-1:0] rd_data_set;
  logic [ARRAY_M*DATA_WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic busy;
  logic done;
  modport master (
    input start, base_addr, num_rows, num_cols, rd_data_set, out_ready,
    output addr_set, enable_set, out_data, out_valid, out_last, busy, done
  );
  modport slave (
    output start, base_addr, num_rows, num_cols, rd_data_set, out_ready,
    input addr_set, enable_set, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/obuf_read_controller.sv
// obuf_read_controller: drains rows of the output RAM into a ready/valid stream through a 2-entry FIFO.
module obuf_read_controller #(
  parameter int RAM_O_SIZE = 256,
  parameter int ARRAY_M = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(RAM_O_SIZE),
  parameter int ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M
) (
  input logic clk,
  input logic reset,
  obuf_read_controller_if.master bus
);
  localparam int CW = $clog2(ARRAY_M) + 1;
  localparam int LW = ARRAY_M * DATA_WIDTH;
  localparam logic [CW-1:0] M_C = CW'(ARRAY_M);
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH:0] row_cnt, rows_q;
  logic [ADDR_WIDTH-1:0] base_q, addr;
  logic [ADDR_SET_WIDTH-1:0] addr_rep;
  logic [CW-1:0] cols_q;
  logic [ARRAY_M-1:0] lane_mask;
  logic inflight, inflight_last;
  logic [LW-1:0] fifo_data [2];
  logic [1:0] fifo_last;
  logic wr_ptr, rd_ptr;
  logic [1:0] count;
  logic [2:0] occ;
  logic pop, issue, last_issue;
  logic [LW-1:0] wdata;
  assign lane_mask = ~({ARRAY_M{1'b1}} << cols_q);
  assign addr = base_q + row_cnt[ADDR_WIDTH-1:0];
  assign addr_rep = {ARRAY_M{addr}};
  assign bus.out_valid = count != 2'd0;
  assign pop = bus.out_valid & bus.out_ready;
  // rows in flight or buffered, less the one leaving this cycle, must leave room in the FIFO
  assign occ = {1'b0, count} + {2'b0, inflight};
  assign issue = state == READ && occ < (pop ? 3'd3 : 3'd2);
  assign last_issue = issue && row_cnt == rows_q - ONE;
  assign bus.enable_set = issue ? lane_mask : '0;
  assign bus.addr_set = issue ? addr_rep : '0;
  assign bus.out_data = fifo_data[rd_ptr];
  assign bus.out_last = bus.out_valid & fifo_last[rd_ptr];
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  for (genvar i = 0; i < ARRAY_M; i++) begin : g_lane
    assign wdata[i*DATA_WIDTH +: DATA_WIDTH] = lane_mask[i] ? bus.rd_data_set[i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.start) state_n = bus.num_rows == '0 ? DONE : READ;
      READ: if (last_issue) state_n = DRAIN;
      DRAIN: if (pop && bus.out_last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row_cnt <= '0;
      rows_q <= '0;
      base_q <= '0;
      cols_q <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        base_q <= bus.base_addr;
        rows_q <= bus.num_rows;
        cols_q <= bus.num_cols > M_C ? M_C : bus.num_cols;
        row_cnt <= '0;
      end else if (issue) row_cnt <= row_cnt + ONE;
      inflight <= issue;
      inflight_last <= last_issue;
      if (inflight) begin
        fifo_data[wr_ptr] <= wdata;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
endmodule

// File: tb/tb_obuf_read_controller.sv
// tb_obuf_read_controller: count-level model of the drain controller checked every cycle, plus directed literal checks.
module tb_obuf_read_controller;
  localparam int M = 8, DW = 16, AW = 8, LW = M * DW;
  typedef struct {logic [LW-1:0] d; bit last;} beat_t;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  obuf_read_controller_if bus();
  obuf_read_controller dut (.clk(clk), .reset(reset), .bus(bus.master));
  int n_chk = 0, n_pass = 0, cyc = 0, start_cyc = 0, d_cyc = -1;
  int iss = 0, acc = 0, arr = 0, m_rows = 0;
  bit active = 0, dflag = 0;
  logic [7:0] m_base, m_mask;
  beat_t exp_q[$];
  int i_cyc[$], b_cyc[$];
  logic [7:0] i_addr[$], i_en[$];
  bit b_last[$];
  logic [LW-1:0] b_data[$];
  function automatic logic [15:0] word(input logic [7:0] a, input int m);
    logic [3:0] l;
    l = m[3:0];
    return {a, l, 4'hA};
  endfunction
  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    for (int m = 0; m < M; m++) bus.rd_data_set[m*DW +: DW] <= word(bus.addr_set[m*AW +: AW], m);
  always @(negedge clk) begin
    bit ev, epop, eiss, edone;
    logic [3:0] c;
    logic [7:0] ea;
    beat_t b;
    if (!reset) begin
      chk("reset_ctl", {bus.out_valid, bus.enable_set, bus.addr_set, bus.out_last, bus.busy, bus.done}, '0);
      chk("reset_data", bus.out_data, '0);
      iss = 0; acc = 0; arr = 0; active = 0; dflag = 0;
      exp_q.delete();
    end else begin
      ev = arr > acc;
      epop = ev && bus.out_ready;
      eiss = active && iss < m_rows && (iss - acc - int'(epop)) < 2;
      edone = dflag;
      ea = m_base + 8'(iss);
      chk("busy", bus.busy, active);
      chk("done", bus.done, edone);
      chk("out_valid", bus.out_valid, ev);
      chk("enable_set", bus.enable_set, eiss ? m_mask : 8'h00);
      if (eiss) chk("addr_set", bus.addr_set, {M{ea}});
      if (ev && exp_q.size() > 0) begin
        chk("out_data", bus.out_data, exp_q[0].d);
        chk("out_last", bus.out_last, exp_q[0].last);
      end
      if (bus.enable_set != 0) begin
        i_cyc.push_back(cyc - start_cyc);
        i_addr.push_back(bus.addr_set[7:0]);
        i_en.push_back(bus.enable_set);
      end
      if (bus.out_valid && bus.out_ready) begin
        b_cyc.push_back(cyc - start_cyc);
        b_last.push_back(bus.out_last);
        b_data.push_back(bus.out_data);
      end
      if (bus.done) d_cyc = cyc - start_cyc;
      if (bus.start && !active) begin
        i_cyc.delete(); i_addr.delete(); i_en.delete();
        b_cyc.delete(); b_last.delete(); b_data.delete();
        d_cyc = -1;
        start_cyc = cyc;
        m_rows = int'(bus.num_rows);
        m_base = bus.base_addr;
        c = bus.num_cols > 4'd8 ? 4'd8 : bus.num_cols;
        m_mask = 8'((9'd1 << c) - 9'd1);
        exp_q.delete();
        for (int r = 0; r < m_rows; r++) begin
          b.d = '0;
          for (int m = 0; m < int'(c); m++) b.d[m*DW +: DW] = word(m_base + 8'(r), m);
          b.last = r == m_rows - 1;
          exp_q.push_back(b);
        end
        iss = 0; acc = 0; arr = 0;
        active = 1;
        dflag = m_rows == 0;
      end else begin
        arr = iss;
        if (eiss) iss++;
        dflag = 0;
        if (epop) begin
          acc++;
          dflag = exp_q[0].last;
          void'(exp_q.pop_front());
        end
        if (edone) active = 0;
      end
    end
  end
  task automatic do_start(input logic [7:0] b, input logic [8:0] r, input logic [3:0] c);
    @(posedge clk); #1;
    bus.base_addr = b; bus.num_rows = r; bus.num_cols = c; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
  endtask
  task automatic run(input bit rnd);
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
      if (!seen) begin
        @(posedge clk); #1;
        if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
    chk("done_within_budget", seen, 1);
    @(posedge clk); #1;
    bus.out_ready = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 0; bus.base_addr = 0; bus.num_rows = 0; bus.num_cols = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    do_start(8'h10, 9'd4, 4'd8);
    run(0);
    chk("t1_issues", i_cyc.size(), 4);
    for (int k = 0; k < i_cyc.size(); k++) begin
      chk("t1_issue_cyc", i_cyc[k], k + 1);
      chk("t1_addr", i_addr[k], 8'h10 + 8'(k));
      chk("t1_en", i_en[k], 8'hFF);
    end
    chk("t1_beats", b_cyc.size(), 4);
    for (int k = 0; k < b_cyc.size(); k++) chk("t1_beat_cyc", b_cyc[k], k + 3);
    chk("t1_last0", b_last[0], 0);
    chk("t1_last3", b_last[3], 1);
    chk("t1_lane0", b_data[0][15:0], 16'h100A);
    chk("t1_lane7", b_data[3][127:112], 16'h137A);
    chk("t1_done_cyc", d_cyc, 7);
    do_start(8'hFE, 9'd4, 4'd12);
    run(0);
    chk("t2_a0", i_addr[0], 8'hFE);
    chk("t2_a1", i_addr[1], 8'hFF);
    chk("t2_a2", i_addr[2], 8'h00);
    chk("t2_a3", i_addr[3], 8'h01);
    chk("t2_clamp_en", i_en[0], 8'hFF);
    do_start(8'h20, 9'd2, 4'd3);
    run(0);
    chk("t3_en", i_en[0], 8'h07);
    chk("t3_hi_lanes", b_data[0][127:48], '0);
    chk("t3_lane2", b_data[0][47:32], 16'h202A);
    do_start(8'h30, 9'd6, 4'd8);
    run(1);
    chk("t4_beats", b_cyc.size(), 6);
    chk("t4_last_row", b_data[5][15:0], 16'h350A);
    do_start(8'h00, 9'd0, 4'd8);
    run(0);
    chk("t5_no_issue", i_cyc.size(), 0);
    chk("t5_no_beat", b_cyc.size(), 0);
    chk("t5_done_cyc", d_cyc, 1);
    do_start(8'h40, 9'd3, 4'd8);
    bus.base_addr = 8'h80; bus.num_rows = 9'd5; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    run(0);
    chk("t5_busy_issues", i_cyc.size(), 3);
    chk("t5_busy_a2", i_addr[2], 8'h42);
    chk("t5_busy_beats", b_cyc.size(), 3);
    do_start(8'h50, 9'd5, 4'd8);
    for (int i = 0; i < 50 && b_cyc.size() < 2; i++) @(negedge clk);
    chk("t6_two_beats", b_cyc.size(), 2);
    @(posedge clk); #3;
    reset = 0;
    #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_en", bus.enable_set, 0);
    chk("t6_rst_addr", bus.addr_set, 0);
    chk("t6_rst_data", bus.out_data, 0);
    chk("t6_rst_last", bus.out_last, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1;
    do_start(8'h60, 9'd3, 4'd8);
    run(0);
    chk("t6_beats", b_cyc.size(), 3);
    chk("t6_a0", i_addr[0], 8'h60);
    chk("t6_lane0", b_data[2][15:0], 16'h620A);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/obuf_read_controller.md
OBUF_READ_CONTROLLER -- requirements
Module: obuf_read_controller

Interface
REQ-001 Parameters SHALL be RAM_O_SIZE=256 (output-RAM words), ARRAY_M=8 (column lanes), DATA_WIDTH=16 (bits per lane), ADDR_WIDTH=$clog2(RAM_O_SIZE), ADDR_SET_WIDTH=ADDR_WIDTH*ARRAY_M.
REQ-002 One clock; reset is asynchronous and active-low; ports SHALL be named clk and reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle request to begin a drain; ignored while busy=1.
REQ-006 base_addr  in  ADDR_WIDTH  first RAM row; sampled on accepted start.
REQ-007 num_rows  in  ADDR_WIDTH+1  rows to drain, 0..RAM_O_SIZE; sampled on accepted start.
REQ-008 num_cols  in  $clog2(ARRAY_M)+1  active lanes; sampled on accepted start; values above ARRAY_M clamp to ARRAY_M.
REQ-009 addr_set  out  ADDR_SET_WIDTH  per-lane read address; lane m at bits [ADDR_WIDTH*m +: ADDR_WIDTH].
REQ-010 enable_set  out  ARRAY_M  per-lane read enable.
REQ-011 rd_data_set  in  ARRAY_M*DATA_WIDTH  RAM read data; valid exactly one cycle after enable.
REQ-012 out_data  out  ARRAY_M*DATA_WIDTH  drained row; out_valid/out_ready handshake.
REQ-013 out_valid  out  1;  out_ready  in  1;  out_last  out  1 (final row of drain).
REQ-014 busy  out  1  drain in progress;  done  out  1  one-cycle completion pulse.

Function
REQ-015 FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-016 IDLE->READ on start with num_rows>0; IDLE->DONE on start with num_rows=0 (no reads, no beats).
REQ-017 READ: a row read SHALL issue in a cycle iff inflight + fifo_count - pop < 2, where pop = out_valid & out_ready in that same cycle.
REQ-018 On issue, every lane SHALL carry address (base_addr + row_cnt) mod RAM_O_SIZE (wraps past RAM_O_SIZE-1 to 0); row_cnt SHALL increment.
REQ-019 enable_set[m] SHALL be 1 iff a row issues in that cycle and m < num_cols; otherwise 0; addr_set is don't-care when not issuing.
REQ-020 READ->DRAIN the cycle after the row with row_cnt = num_rows-1 issues.
REQ-021 rd_data_set SHALL be captured into a 2-entry FIFO one cycle after issue; lanes m >= num_cols SHALL be written as zero.
REQ-022 out_valid SHALL be 1 iff the FIFO is non-empty; out_data is the FIFO head; out_data and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 out_last SHALL be 1 only on the beat for row num_rows-1.
REQ-024 DRAIN->DONE when the out_last beat is accepted; DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-025 busy SHALL be 1 in READ, DRAIN and DONE.
REQ-026 Latency: start accepted at cycle 0 -> first issue at cycle 1 -> out_valid at cycle 3 earliest; with out_ready held high, one beat per cycle sustained.
REQ-027 FIFO SHALL never overflow; no beat SHALL be dropped or duplicated under any out_ready pattern.

Reset
REQ-028 On reset low: state=IDLE, row_cnt=0, inflight=0, FIFO empty; enable_set=0, out_valid=0, out_last=0, busy=0, done=0, addr_set=0, out_data=0.
REQ-029 Reset asserted mid-drain SHALL abort immediately; after release the block SHALL be IDLE and accept a new start.

Verification
REQ-030 base=0x10, rows=4, cols=8, out_ready=1 -> addr 0x10..0x13 at cycles 1-4, enable_set=0xFF each; 4 beats cycles 3-6, out_last on 4th, done cycle 7.
REQ-031 base=0xFE, rows=4 -> addresses 0xFE, 0xFF, 0x00, 0x01 in order.
REQ-032 cols=3 -> enable_set=0x07; out_data lanes 3..7 = 0 even with nonzero rd_data_set.
REQ-033 rows=6, out_ready random 50% -> 6 beats in order, data matches RAM model, no enable issued while 2 rows pending.
REQ-034 rows=0 -> no enables, no beats, done pulse cycle 1; start during busy -> ignored, parameters unchanged.
REQ-035 Reset pulled low after 2 beats of 5 -> all outputs at reset values asynchronously; new start after release drains correctly.
